// File: rtl/keypad_entry_if.sv
// keypad_entry_if: keypad matrix lines plus the accumulated number and key report
interface keypad_entry_if;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [13:0] number;
  logic [3:0]  key_code;
  logic        key_strobe;
  logic        valid;
  modport master (input row, output col, number, key_code, key_strobe, valid);
  modport slave  (output row, input col, number, key_code, key_strobe, valid);
endinterface

// File: rtl/keypad_entry.sv
// keypad_entry: scans a 4x4 keypad, debounces presses and builds a 0..9999 decimal entry
module keypad_entry #(
  parameter int SCAN_DIV = 100_000,
  parameter int DEBOUNCE = 4
) (
  input logic            clk,
  input logic            rst,
  keypad_entry_if.master bus
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(DEBOUNCE + 1);
  // key code per matrix position, indexed by row*4+col
  localparam logic [63:0] CODES = 64'hDF0E_C987_B654_A321;
  typedef enum logic {IDLE, HELD} state_t;
  state_t          state;
  logic [3:0]      row_m, row_s;
  logic [CW-1:0]   cnt;
  logic [1:0]      ci;
  logic [15:0]     keys, frame;
  logic [DW-1:0]   dcnt, dn;
  logic [3:0]      last, idx, code;
  logic [4:0]      ones;
  logic            sample, eval, single, accept, done;
  logic [13:0]     num_next;
  assign bus.col = ~(4'b0001 << ci);
  always_comb begin
    sample = cnt == CW'(SCAN_DIV - 1);
    eval   = sample && ci == 2'd3;
    frame  = keys;
    idx    = '0;
    ones   = '0;
    for (int r = 0; r < 4; r++) frame[r*4+3] = ~row_s[r];
    for (int i = 0; i < 16; i++)
      if (frame[i]) begin
        ones = ones + 5'd1;
        idx  = 4'(i);
      end
    single = ones == 5'd1;
    code   = CODES[idx*4 +: 4];
    // multi-key frames count as "no key" both for press and release
    dn     = state == IDLE ? (single ? ((dcnt != '0 && code == last) ? dcnt + DW'(1) : DW'(1)) : '0)
                           : (single ? '0 : dcnt + DW'(1));
    done   = dn == DW'(DEBOUNCE);
    accept = eval && state == IDLE && single && done;
    num_next = code <= 4'd9 ? (bus.number < 14'd1000 ? bus.number * 14'd10 + {10'd0, code} : bus.number)
             : code == 4'hA ? bus.number / 14'd10
             : code == 4'hE ? 14'd0
             : bus.number;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      row_m          <= 4'hF;
      row_s          <= 4'hF;
      cnt            <= '0;
      ci             <= '0;
      keys           <= '0;
      dcnt           <= '0;
      last           <= '0;
      bus.number     <= '0;
      bus.key_code   <= '0;
      bus.key_strobe <= 1'b0;
      bus.valid      <= 1'b0;
    end else begin
      row_m          <= bus.row;
      row_s          <= row_m;
      cnt            <= sample ? '0 : cnt + CW'(1);
      bus.key_strobe <= accept;
      bus.valid      <= accept && code == 4'hF;
      if (sample) begin
        ci <= ci + 2'd1;
        for (int r = 0; r < 4; r++) keys[r*4 + int'(ci)] <= ~row_s[r];
      end
      if (eval) begin
        dcnt  <= done ? '0 : dn;
        last  <= code;
        state <= done ? (state == IDLE ? HELD : IDLE) : state;
      end
      if (accept) begin
        bus.key_code <= code;
        bus.number   <= num_next;
      end
    end
  end
endmodule

// File: tb/tb_keypad_entry.sv
// tb_keypad_entry: keypad matrix model driving keypad_entry, scoreboard of expected key reports
module tb_keypad_entry;
  localparam int K1 = 0, K2 = 1, K3 = 2, KA = 3, K4 = 4, K5 = 5, K7 = 8, K8 = 9, K9 = 10, KS = 12, KH = 14;
  typedef struct {int code; int num; int vld;} exp_t;
  logic        clk, rst;
  logic [15:0] pressed;
  logic [3:0]  row_v;
  logic        ks_q;
  int          checks, errors, mnum;
  int          kmap [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};
  exp_t        q [$];
  keypad_entry_if bus ();
  keypad_entry #(.SCAN_DIV(4), .DEBOUNCE(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always_comb begin
    row_v = 4'hF;
    for (int r = 0; r < 4; r++) row_v[r] = ~|(pressed[r*4 +: 4] & ~bus.col);
  end
  assign bus.row = row_v;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.key_strobe) begin
        exp_t e;
        chk("strobe_width", 32'(ks_q), 0);
        chk("sb_pending", 32'(q.size() != 0), 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("key_code", 32'(bus.key_code), e.code);
          chk("number_at_strobe", 32'(bus.number), e.num);
          chk("valid_at_strobe", 32'(bus.valid), e.vld);
        end
      end else chk("valid_idle", 32'(bus.valid), 0);
      ks_q <= bus.key_strobe;
    end else ks_q <= 1'b0;
  end
  task automatic hold(input logic [15:0] k, input int frames);
    pressed = k;
    repeat (frames * 16) @(negedge clk);
  endtask
  task automatic expect_key(input int idx);
    int c;
    c = kmap[idx];
    if (c <= 9) mnum = mnum < 1000 ? mnum * 10 + c : mnum;
    else if (c == 10) mnum = mnum / 10;
    else if (c == 14) mnum = 0;
    q.push_back('{c, mnum, int'(c == 15)});
  endtask
  task automatic press(input int idx, input int hf, input int rf, input bit exp);
    if (exp) expect_key(idx);
    hold(16'(1) << idx, hf);
    hold('0, rf);
  endtask
  initial begin
    rst = 1'b1;
    pressed = '0;
    checks = 0;
    errors = 0;
    mnum = 0;
    repeat (3) @(negedge clk);
    chk("rst_col", 32'(bus.col), 4'b1110);
    chk("rst_number", 32'(bus.number), 0);
    chk("rst_strobe", 32'(bus.key_strobe), 0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      chk("scan_col", 32'(bus.col), 32'(~(4'b0001 << ((i / 4) % 4)) & 4'hF));
      @(negedge clk);
    end
    chk("idle_number", 32'(bus.number), 0);
    press(K1, 4, 4, 1'b1); chk("num_1", 32'(bus.number), 1);
    press(K2, 4, 4, 1'b1); chk("num_12", 32'(bus.number), 12);
    press(K3, 4, 4, 1'b1); chk("num_123", 32'(bus.number), 123);
    press(K4, 4, 4, 1'b1); chk("num_1234", 32'(bus.number), 1234);
    press(K5, 4, 4, 1'b1); chk("num_full", 32'(bus.number), 1234);
    press(KA, 4, 4, 1'b1); chk("num_bksp", 32'(bus.number), 123);
    press(KH, 4, 4, 1'b1); chk("num_enter", 32'(bus.number), 123);
    press(KS, 4, 4, 1'b1); chk("num_clear", 32'(bus.number), 0);
    hold(16'(1) << K9, 1);
    hold('0, 4);
    hold((16'(1) << K1) | (16'(1) << K5), 6);
    hold('0, 4);
    chk("num_glitch", 32'(bus.number), 0);
    chk("sb_glitch", 32'(q.size()), 0);
    expect_key(K7);
    hold(16'(1) << K7, 10);
    hold(16'(1) << K8, 4);
    chk("num_rollover", 32'(bus.number), 7);
    chk("sb_rollover", 32'(q.size()), 0);
    hold('0, 4);
    press(K8, 4, 4, 1'b1); chk("num_78", 32'(bus.number), 78);
    press(KS, 4, 4, 1'b1);
    press(K4, 4, 4, 1'b1);
    expect_key(K5);
    hold(16'(1) << K5, 4);
    chk("num_45", 32'(bus.number), 45);
    chk("key_code_held", 32'(bus.key_code), 5);
    @(posedge clk);
    #2 rst = 1'b1;
    #2;
    chk("arst_number", 32'(bus.number), 0);
    chk("arst_col", 32'(bus.col), 4'b1110);
    chk("arst_key_code", 32'(bus.key_code), 0);
    chk("arst_strobe", 32'(bus.key_strobe), 0);
    chk("arst_valid", 32'(bus.valid), 0);
    mnum = 0;
    expect_key(K5);
    @(negedge clk);
    rst = 1'b0;
    hold(16'(1) << K5, 4);
    hold('0, 4);
    chk("num_after_rst", 32'(bus.number), 5);
    chk("sb_drained", 32'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/keypad_entry.md
# keypad_entry

Scans a 4x4 matrix keypad, debounces key presses and accumulates a 4-digit decimal number (0-9999) for the 14-bit `number` input of the 4-digit seven-segment display driver. It drives active-low column strobes, reads active-low rows, and accepts one key per press. It also provides clear, backspace and enter functions, and reports each accepted key to the rest of the design.

## Interface
- `SCAN_DIV`, 100_000: clock cycles per column period (≥ 4).
- `DEBOUNCE`, 4: consecutive identical scan frames required to accept a press or a release (≥ 1).

Ports:
- `clk`  in  1  system clock; the block uses this single clock only.
- `rst`  in  1  reset, asynchronous and active-high; clears all state immediately.
- `row`  in  4  keypad rows, active-low, externally pulled up, asynchronous to `clk`.
- `col`  out  4  column drive, active-low one-hot.
- `number`  out  14  accumulated value, 0..9999.
- `key_code`  out  4  code of the last accepted key.
- `key_strobe`  out  1  one-cycle pulse for each accepted key.
- `valid`  out  1  one-cycle pulse when enter (`#`) is accepted.

## Operation
- Key map, row r / col c:
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: * 0 # D
- Codes: digits 0-9 map to 4'h0-4'h9; A-D map to 4'hA-4'hD; `*` is 4'hE; `#` is 4'hF.
- Synchronizer: `row` passes through a 2-flop synchronizer. All sampling uses the synchronized value.
- Scan counter:
  - Counts 0..`SCAN_DIV`-1. At the count of `SCAN_DIV`-1 the block samples the synchronized rows for the active column, then advances `col` through 1110 → 1101 → 1011 → 0111 → 1110.
  - A frame is the four column periods. The frame is evaluated at the column-3 sample edge.
- Frame result:
  - None: no key is low.
  - Key k: exactly one key is low.
  - Multi: two or more keys are low. Multi is treated as none for debounce purposes.
- Debounce FSM:
  - IDLE: if the frame result equals the previous frame's key k for `DEBOUNCE` consecutive frames, accept k and go to HELD. A changing key restarts the count.
  - HELD: the block ignores every key, including a different key pressed without release. It returns to IDLE after `DEBOUNCE` consecutive none frames. A single non-none frame restarts the release count.
- Accepting a key sets `key_code` to k and pulses `key_strobe`, then applies the action below.
- Key actions:
  - Digit d: if `number` < 1000, `number` becomes `number`*10 + d. Otherwise `number` is unchanged; the strobe still fires.
  - A (backspace): `number` becomes `number`/10.
  - `*` (clear): `number` becomes 0.
  - `#` (enter): `number` is unchanged; `valid` pulses.
  - B, C, D: strobe only.
- Arithmetic: the maximum result is 999*10+9 = 9999, which fits in 14 bits. No wrap is possible.

## Timing
- Reset values: `col`=4'b1110, `number`=0, `key_code`=0, `key_strobe`=0, `valid`=0. Scan counter, synchronizer, frame register and debounce count are cleared; FSM is IDLE.
- Reset asserting mid-scan, mid-debounce or in HELD returns to the reset state with no clock edge.
  - After `rst` deasserts, the scan restarts at column 0.
  - A key still held after reset is treated as a new press.
- `col` changes on the edge after the sample at count `SCAN_DIV`-1. Each column is active for exactly `SCAN_DIV` cycles.
- `key_strobe`, `key_code`, `number` and `valid` are all registered on the column-3 sample edge of the frame that completes debounce.
  - `key_strobe` and `valid` are high for exactly one cycle.
  - The new `number` appears in the same cycle as `key_strobe`.
- Press latency, from a stable `row` to `key_strobe`: 2 synchronizer cycles plus `DEBOUNCE` frames, rounded up to a frame boundary.
- At most one `key_strobe` per frame.

## Test plan
Run the bench with `SCAN_DIV`=4 and `DEBOUNCE`=2, giving 16-cycle frames. The keypad model pulls `row`[r] low while `col`[c]=0 for a pressed key (r,c).

1. Reset, then run 20 cycles → `col` follows 1110, 1101, 1011, 0111, 1110 with 4 cycles each; `number`=0; no strobes.
2. Press 1, 2, 3; hold each 4 frames and release each 4 frames → three `key_strobe` pulses with `key_code` 1, 2, 3; `number` reads 1, 12, 123.
3. From 123:
   - Press 4, then 5 → `number`=1234, and stays 1234 after 5 (strobe with `key_code`=5).
   - Press A → `number`=123.
   - Press # → `valid` pulses once with `number`=123.
   - Press * → `number`=0.
4. Glitch and ghosting:
   - Press 9 for 1 frame → no strobe.
   - Press 1 and 5 together for 6 frames → no strobe; `number` unchanged.
5. Hold 7 for 10 frames, then switch to 8 without releasing → exactly one strobe (`key_code`=7), `number`=7; 8 is accepted only after a 2-frame release and a fresh 2-frame press.
6. Assert `rst` asynchronously between clock edges while in HELD with `number`=45 → outputs read reset values before the next edge; with the key still held after deassert, a new strobe follows after debounce.
